serial_frame_rx: RTL
====================

// Module: serial_frame_rx
// PURPOSE
//  Downstream stage of the 4-bit shift register. Consumes its serial output
//  (s_out) one bit per enabled cycle and assembles framed words.
//  Frame: start(1), DW data bits, optional even parity, stop(0).
//  Delivers each word on a valid/ready output port with parity, framing and
//  overrun status.
// PARAMETERS
//  DW         4   data bits per frame (>=2)
//  PARITY_EN  1   1: even-parity bit follows data; 0: no parity bit
// PORTS
//  clk         in   1    rising-edge clock (single clock domain)
//  reset_n     in   1    asynchronous reset, active low
//  bit_vld     in   1    strobe: s_in holds a valid bit this cycle (= upstream enb)
//  s_in        in   1    serial data (upstream s_out)
//  dir         in   1    0: MSB first (left shift upstream); 1: LSB first
//  out_data    out  DW   received word
//  out_valid   out  1    out_data/out_perr valid; held until out_ready
//  out_ready   in   1    consumer accepts word when out_valid&&out_ready
//  out_perr    out  1    parity error attached to out_data
//  frame_err   out  1    1-cycle pulse: stop bit read as 1
//  overrun     out  1    1-cycle pulse: completed word dropped (port full)
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, bit counter=0, shift reg=0,
//   out_data=0, out_valid=0, out_perr=0, frame_err=0, overrun=0.
//   Reset mid-frame discards the partial frame.
//  All state advances only on cycles with bit_vld=1; bit_vld=0 cycles freeze
//   the FSM (counter, shift reg, running parity hold).
//  FSM:
//   IDLE:   bit_vld&&s_in==1 -> DATA; latch dir, cnt=0, parity acc=0.
//           s_in==0 is idle line, stay.
//   DATA:   each bit_vld stores s_in and xors parity acc; cnt++.
//           After DW-th bit -> PARITY (PARITY_EN=1) or STOP.
//           dir=0: shift left, first bit ends in [DW-1];
//           dir=1: shift right, first bit ends in [0].
//   PARITY: bit_vld: perr = acc ^ s_in (even parity over data+parity) -> STOP.
//   STOP:   bit_vld&&s_in==0: frame complete -> IDLE.
//           bit_vld&&s_in==1: frame_err pulse next cycle, word dropped -> IDLE.
//  Latency: out_valid rises the cycle after the stop-bit bit_vld edge.
//  Output port (1-entry holding reg):
//   - out_valid&&out_ready at an edge clears out_valid unless a new word
//     loads the same edge.
//   - Completion with port empty, or full but out_ready=1 the same cycle:
//     load new word, out_valid=1.
//   - Completion with out_valid=1&&out_ready=0: keep old word, overrun
//     pulse 1 cycle.
//  dir is sampled only at start bit; changes mid-frame are ignored.
//  Back-to-back frames: start bit may arrive on the bit_vld right after stop.
//  frame_err/overrun are registered single-cycle pulses, 0 otherwise.
// TESTING (DW=4, PARITY_EN=1)
//  1 dir=0, bits 1,1,0,1,1,1,0 on consecutive bit_vld, out_ready=1
//    -> out_data=4'hB, out_perr=0, out_valid 1 cycle after stop.
//  2 dir=1, same bit stream -> out_data=4'hD, out_perr=0.
//  3 dir=0, bits 1,1,0,1,1,0(parity bad),0 -> out_data=4'hB, out_perr=1.
//  4 stop bit=1 -> frame_err pulse, out_valid stays 0, FSM back in IDLE.
//  5 out_ready=0, two good frames (4'hB then 4'h3)
//    -> out_data stays 4'hB, overrun pulse at 2nd completion.
//  6 reset_n=0 after 2 data bits, release, send full frame 4'h6
//    -> only 4'h6 delivered.
//  7 bit_vld gaps (0 between every bit) -> results identical to scenario 1.

Source files
------------

// File: rtl/serial_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_frame_rx
//  Description : Serial frame receiver placed after the 4-bit shift register.
//                Frame = start(1), DW data bits, optional even parity,
//                stop(0). Each completed word goes out through a 1-entry
//                valid/ready holding register. The word carries a parity
//                error flag. Framing-error and overrun status are reported
//                as single-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_frame_rx #(
   parameter int DW        = 4,
   parameter int PARITY_EN = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          bit_vld,
   input  logic          s_in,
   input  logic          dir,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_perr,
   output logic          frame_err,
   output logic          overrun
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [DW-1:0] shreg, shreg_nx;
   logic          acc, acc_nx;
   logic          dir_q, dir_nx;
   logic          perr_q, perr_nx;
   logic          done;
   logic          stop_bad;
   logic          load;

   // Receive FSM and its datapath registers; everything holds when bit_vld=0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         shreg  <= '0;
         acc    <= 1'b0;
         dir_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         shreg  <= shreg_nx;
         acc    <= acc_nx;
         dir_q  <= dir_nx;
         perr_q <= perr_nx;
      end
   end

   // Next-state and datapath update, advanced only on valid bit strobes
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      acc_nx   = acc;
      dir_nx   = dir_q;
      perr_nx  = perr_q;
      done     = 1'b0;
      stop_bad = 1'b0;
      if (bit_vld) begin
         case (state)
            IDLE: begin
               // A 1 on the line is the start bit; direction is frozen here
               if (s_in) begin
                  state_nx = DATA;
                  cnt_nx   = '0;
                  acc_nx   = 1'b0;
                  dir_nx   = dir;
                  perr_nx  = 1'b0;
               end
            end
            DATA: begin
               shreg_nx = dir_q ? {s_in, shreg[DW-1:1]} : {shreg[DW-2:0], s_in};
               acc_nx   = acc ^ s_in;
               if (cnt == CW'(DW - 1)) begin
                  cnt_nx   = '0;
                  state_nx = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            PARITY: begin
               // Even parity: data bits plus parity bit must XOR to zero
               perr_nx  = acc ^ s_in;
               state_nx = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (s_in) stop_bad = 1'b1;
               else      done     = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // A finished word is accepted when the port is empty or is being drained
   assign load = done && (!out_valid || out_ready);

   // Output holding register and registered status pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_perr  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            out_data  <= shreg;
            out_perr  <= perr_q;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         frame_err <= stop_bad;
         overrun   <= done && out_valid && !out_ready;
      end
   end

endmodule
`default_nettype wire
